morse_translator_core: RTL and testbench
========================================

Name: morse_translator_core

Overview:
- Single-clock Morse front end plus translator.
- Decodes push-button events (Dot, Dash, Space, EndSeq) into a symbol code per letter and translates each completed letter to 8-bit ASCII.
- Buffers up to 16 characters and publishes them as a 128-bit string on Enter.
- Feeds the display/storage path of the translator system.

Parameters:
- MAX_CHARS, 16, character slots in the buffer; the output width is 8*MAX_CHARS.
- MAX_SYMBOLS, 5, dots/dashes accepted per letter; the code width is 2*MAX_SYMBOLS.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Dot  input  1  dot button, level, synchronous to Clk.
- Dash  input  1  dash button.
- Space  input  1  end-of-letter button.
- EndSeq  input  1  end-of-word button.
- Enter  input  1  publish the buffer to the output.
- Clear  input  1  discard the current letter and the buffer.
- translatedCharacters  output  128  published string; char 0 in [127:120], unused slots are 0x00.
- CharCount  output  5  number of characters in the buffer, 0..16.
- Full  output  1  high when CharCount==16.
- Valid  output  1  one-cycle pulse in the cycle after a publish.

Behaviour:
- Reset low (asynchronous): clear every register. Outputs are 0, CharCount=0, Full=0, Valid=0, code accumulator empty, error flag 0.
- Event detection: each of the six inputs is registered. An event is current=1 and previous=0, so a held button acts once.
- Button priority in one cycle: Clear > EndSeq > Space > Dash > Dot. Only the highest-priority of these fires. Enter is handled independently.
- Signal encoding (internal 3-bit): none=000, dot=001, dash=010, space=011, endseq=100.
- Code accumulator: 10 bits with a symbol count 0..5.
  - Symbol k (0-based) is stored in bits [9-2k:8-2k]; dot=01, dash=10, unused=00.
  - A 6th or later symbol sets the error flag and leaves the code unchanged.
- Space:
  - Accumulator non-empty: translate, append the char at slot CharCount, clear the accumulator and error flag.
  - Accumulator empty: no action.
- EndSeq: same as Space, then append 0x20. Each append is independently dropped if the buffer is full.
- Translation (combinational, ITU Morse): A–Z to 0x41–0x5A, 0–9 to 0x30–0x39. Unmatched codes or error flag set give 0x3F ('?').
- Buffer full: further appends are dropped. The accumulator still clears on Space/EndSeq.
- Clear: empty the accumulator and buffer, set CharCount=0. translatedCharacters is unchanged until the next Enter.
- Enter event:
  - At the same edge, translatedCharacters is loaded with the buffer as it stands after any same-cycle append.
  - Valid pulses high in the following cycle.
  - The buffer is retained, not cleared.
- Enter together with Clear publishes the emptied buffer (all zeros).
- Latency: button edge at cycle N is registered at N, the event acts at N+1, and the published output is visible after the N+1 edge.

Test Plan:
- Dot, Dash, Space, Enter (separate pulses) -> translatedCharacters[127:120]=0x41, remaining bits 0, CharCount=1, Valid pulses once.
- "SOS": ... Space --- Space ... Space Enter -> top 24 bits 0x534F53, CharCount=3.
- Dot x6, Space, Enter -> char 0x3F. Dash x5, Space -> '0' (0x30). Dot x5 -> '5' (0x35).
- Dot, EndSeq, Dot, Space, Enter -> 0x45 20 45, CharCount=3. EndSeq alone on an empty accumulator -> 0x20.
- 17 letters 'E' then Enter -> sixteen 0x45 bytes, Full=1, CharCount=16, 17th dropped. Clear then Enter -> output 0, Full=0.
- Reset pulsed low mid-letter, asynchronous to Clk -> outputs 0 immediately. The next Dot, Space, Enter yields 0x45 only.
- Held Dot for 5 cycles, then Space, then Enter -> single 'E' (0x45).
- Dot and Dash asserted in the same cycle -> counts as a Dash.

Source files
------------

// File: rtl/morse_translator_core.sv
// Morse front end: edge-detects button presses, accumulates dot/dash codes per letter,
// translates completed letters to ASCII and publishes a character buffer on Enter.
module morse_translator_core #(
    parameter int MAX_CHARS   = 16,
    parameter int MAX_SYMBOLS = 5,
    localparam int CODE_W = 2 * MAX_SYMBOLS,
    localparam int OUT_W  = 8 * MAX_CHARS,
    localparam int CNT_W  = $clog2(MAX_CHARS + 1),
    localparam int SYM_W  = $clog2(MAX_SYMBOLS + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Dot,
    input  logic             Dash,
    input  logic             Space,
    input  logic             EndSeq,
    input  logic             Enter,
    input  logic             Clear,
    output logic [OUT_W-1:0] translatedCharacters,
    output logic [CNT_W-1:0] CharCount,
    output logic             Full,
    output logic             Valid
);

    typedef enum logic [2:0] {
        SIG_NONE   = 3'b000,
        SIG_DOT    = 3'b001,
        SIG_DASH   = 3'b010,
        SIG_SPACE  = 3'b011,
        SIG_ENDSEQ = 3'b100
    } sig_t;

    logic [5:0]        btn_d, btn_q, btn_prev_d, btn_prev_q, ev;
    logic [CODE_W-1:0] code_d, code_q;
    logic [SYM_W-1:0]  nsym_d, nsym_q;
    logic              err_d, err_q;
    logic [OUT_W-1:0]  buf_d, buf_q, out_d, out_q;
    logic [CNT_W-1:0]  count_d, count_q, slot;
    logic              valid_d, valid_q;
    logic [1:0]        sym;
    logic [7:0]        ch;
    sig_t              sig;

    // Codes are left-justified: first symbol in the top two bits.
    function automatic logic [7:0] translate(input logic [CODE_W-1:0] code, input logic err);
        logic [7:0] c;
        case (code)
            10'b01_10_00_00_00: c = 8'h41;
            10'b10_01_01_01_00: c = 8'h42;
            10'b10_01_10_01_00: c = 8'h43;
            10'b10_01_01_00_00: c = 8'h44;
            10'b01_00_00_00_00: c = 8'h45;
            10'b01_01_10_01_00: c = 8'h46;
            10'b10_10_01_00_00: c = 8'h47;
            10'b01_01_01_01_00: c = 8'h48;
            10'b01_01_00_00_00: c = 8'h49;
            10'b01_10_10_10_00: c = 8'h4A;
            10'b10_01_10_00_00: c = 8'h4B;
            10'b01_10_01_01_00: c = 8'h4C;
            10'b10_10_00_00_00: c = 8'h4D;
            10'b10_01_00_00_00: c = 8'h4E;
            10'b10_10_10_00_00: c = 8'h4F;
            10'b01_10_10_01_00: c = 8'h50;
            10'b10_10_01_10_00: c = 8'h51;
            10'b01_10_01_00_00: c = 8'h52;
            10'b01_01_01_00_00: c = 8'h53;
            10'b10_00_00_00_00: c = 8'h54;
            10'b01_01_10_00_00: c = 8'h55;
            10'b01_01_01_10_00: c = 8'h56;
            10'b01_10_10_00_00: c = 8'h57;
            10'b10_01_01_10_00: c = 8'h58;
            10'b10_01_10_10_00: c = 8'h59;
            10'b10_10_01_01_00: c = 8'h5A;
            10'b10_10_10_10_10: c = 8'h30;
            10'b01_10_10_10_10: c = 8'h31;
            10'b01_01_10_10_10: c = 8'h32;
            10'b01_01_01_10_10: c = 8'h33;
            10'b01_01_01_01_10: c = 8'h34;
            10'b01_01_01_01_01: c = 8'h35;
            10'b10_01_01_01_01: c = 8'h36;
            10'b10_10_01_01_01: c = 8'h37;
            10'b10_10_10_01_01: c = 8'h38;
            10'b10_10_10_10_01: c = 8'h39;
            default:            c = 8'h3F;
        endcase
        return err ? 8'h3F : c;
    endfunction

    function automatic logic [OUT_W-1:0] put_char(input logic [OUT_W-1:0] b,
                                                  input logic [CNT_W-1:0] s,
                                                  input logic [7:0] c);
        logic [OUT_W-1:0] r;
        r = b;
        for (int i = 0; i < MAX_CHARS; i++) begin
            if (int'(s) == i) r[OUT_W-1-8*i -: 8] = c;
        end
        return r;
    endfunction

    always_comb begin
        btn_d      = {Clear, Enter, EndSeq, Space, Dash, Dot};
        btn_prev_d = btn_q;
        ev         = btn_q & ~btn_prev_q;
        code_d     = code_q;
        nsym_d     = nsym_q;
        err_d      = err_q;
        buf_d      = buf_q;
        out_d      = out_q;
        valid_d    = ev[4];
        slot       = count_q;
        ch         = translate(code_q, err_q);
        sym        = 2'b01;
        sig        = SIG_NONE;

        if (ev[3])      sig = SIG_ENDSEQ;
        else if (ev[2]) sig = SIG_SPACE;
        else if (ev[1]) sig = SIG_DASH;
        else if (ev[0]) sig = SIG_DOT;

        if (ev[5]) begin
            code_d = '0;
            nsym_d = '0;
            err_d  = 1'b0;
            buf_d  = '0;
            slot   = '0;
        end else begin
            case (sig)
                SIG_DOT, SIG_DASH: begin
                    sym = (sig == SIG_DASH) ? 2'b10 : 2'b01;
                    if (int'(nsym_q) < MAX_SYMBOLS) begin
                        for (int k = 0; k < MAX_SYMBOLS; k++) begin
                            if (int'(nsym_q) == k) code_d[CODE_W-1-2*k -: 2] = sym;
                        end
                        nsym_d = nsym_q + SYM_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                SIG_SPACE, SIG_ENDSEQ: begin
                    // Each append is dropped on its own when the buffer is full.
                    if (nsym_q != '0) begin
                        if (int'(slot) < MAX_CHARS) begin
                            buf_d = put_char(buf_d, slot, ch);
                            slot  = slot + CNT_W'(1);
                        end
                        code_d = '0;
                        nsym_d = '0;
                        err_d  = 1'b0;
                    end
                    if (sig == SIG_ENDSEQ && int'(slot) < MAX_CHARS) begin
                        buf_d = put_char(buf_d, slot, 8'h20);
                        slot  = slot + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end

        count_d = slot;
        if (ev[4]) out_d = buf_d;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            btn_q      <= '0;
            btn_prev_q <= '0;
            code_q     <= '0;
            nsym_q     <= '0;
            err_q      <= 1'b0;
            buf_q      <= '0;
            count_q    <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            btn_q      <= btn_d;
            btn_prev_q <= btn_prev_d;
            code_q     <= code_d;
            nsym_q     <= nsym_d;
            err_q      <= err_d;
            buf_q      <= buf_d;
            count_q    <= count_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
        end
    end

    assign translatedCharacters = out_q;
    assign CharCount            = count_q;
    assign Full                 = (int'(count_q) == MAX_CHARS);
    assign Valid                = valid_q;

endmodule

// File: tb/tb_morse_translator_core.sv
// Bench for morse_translator_core: table of button sequences, scoreboard of publishes
// checked on Valid, plus hand sequences for reset, held buttons and Clear/Enter.
module tb_morse_translator_core;

    logic         Clk = 1'b0;
    logic         Reset, Dot, Dash, Space, EndSeq, Enter, Clear;
    logic [127:0] translatedCharacters;
    logic [4:0]   CharCount;
    logic         Full, Valid;

    morse_translator_core dut (
        .Clk(Clk), .Reset(Reset), .Dot(Dot), .Dash(Dash), .Space(Space),
        .EndSeq(EndSeq), .Enter(Enter), .Clear(Clear),
        .translatedCharacters(translatedCharacters), .CharCount(CharCount),
        .Full(Full), .Valid(Valid)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [319:0] seq;
        logic [127:0] expOut;
        logic [4:0]   expCnt;
        logic         expFull;
    } vec_t;

    typedef struct packed {
        logic [127:0] out;
        logic [4:0]   cnt;
        logic         full;
    } exp_t;

    exp_t sbQueue[$];
    vec_t vecs[12];
    int   nTests = 0;
    int   nFail  = 0;
    int   nEnter = 0;
    int   nValid = 0;

    localparam logic [5:0] B_DOT = 6'b000001, B_DASH = 6'b000010, B_SPACE = 6'b000100,
                           B_END = 6'b001000, B_ENTER = 6'b010000, B_CLEAR = 6'b100000;

    function automatic vec_t mk(input logic [319:0] s, input logic [127:0] o, input int c, input logic f);
        vec_t v;
        v.seq = s; v.expOut = o; v.expCnt = 5'(c); v.expFull = f;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one button pattern for a cycle, then release it for a cycle.
    task automatic applyStimulus(input logic [5:0] b);
        {Clear, Enter, EndSeq, Space, Dash, Dot} = b;
        @(negedge Clk);
        {Clear, Enter, EndSeq, Space, Dash, Dot} = 6'b0;
        @(negedge Clk);
    endtask

    task automatic sendEnter(input exp_t e, input logic withClear);
        sbQueue.push_back(e);
        nEnter++;
        applyStimulus(withClear ? (B_ENTER | B_CLEAR) : B_ENTER);
    endtask

    task automatic runSeq(input logic [319:0] seq, input exp_t e);
        logic [7:0] c;
        applyStimulus(B_CLEAR);
        for (int i = 39; i >= 0; i--) begin
            c = seq[8*i +: 8];
            if (c == ".")      applyStimulus(B_DOT);
            else if (c == "-") applyStimulus(B_DASH);
            else if (c == " ") applyStimulus(B_SPACE);
            else if (c == "/") applyStimulus(B_END);
            else if (c == "B") applyStimulus(B_DOT | B_DASH);
        end
        sendEnter(e, 1'b0);
    endtask

    task automatic drain();
        int w = 0;
        while (sbQueue.size() != 0 && w < 50) begin
            @(negedge Clk);
            w++;
        end
        nTests++;
        if (sbQueue.size() != 0) begin
            nFail++;
            $display("[TB] FAIL drain: %0d publishes never seen, expected 0", sbQueue.size());
            sbQueue.delete();
        end
    endtask

    // Scoreboard consumer: every Valid pulse pops and compares one publish.
    initial begin
        exp_t e;
        logic prevValid = 1'b0;
        forever begin
            @(negedge Clk);
            if (Reset && Valid) begin
                nValid++;
                checkOutput("validPulseWidth", 128'(prevValid), 128'h0);
                if (sbQueue.size() == 0) begin
                    nTests++;
                    nFail++;
                    $display("[TB] FAIL unexpectedValid: got Valid=1, expected no publish");
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("publishOut", translatedCharacters, e.out);
                    checkOutput("publishCount", 128'(CharCount), 128'(e.cnt));
                    checkOutput("publishFull", 128'(Full), 128'(e.full));
                end
            end
            prevValid = Reset && Valid;
        end
    end

    initial begin
        vecs[0]  = mk(".- ", {8'h41, 120'h0}, 1, 1'b0);
        vecs[1]  = mk("... --- ... ", {8'h53, 8'h4F, 8'h53, 104'h0}, 3, 1'b0);
        vecs[2]  = mk("...... ", {8'h3F, 120'h0}, 1, 1'b0);
        vecs[3]  = mk("----- ..... ", {8'h30, 8'h35, 112'h0}, 2, 1'b0);
        vecs[4]  = mk("./. ", {8'h45, 8'h20, 8'h45, 104'h0}, 3, 1'b0);
        vecs[5]  = mk("/", {8'h20, 120'h0}, 1, 1'b0);
        vecs[6]  = mk("B ", {8'h54, 120'h0}, 1, 1'b0);
        vecs[7]  = mk("-... -.-. ..--- --... ", {8'h42, 8'h43, 8'h32, 8'h37, 96'h0}, 4, 1'b0);
        vecs[8]  = mk(".-.-. ---.. --.- .--- .---- ",
                      {8'h3F, 8'h38, 8'h51, 8'h4A, 8'h31, 88'h0}, 5, 1'b0);
        vecs[9]  = mk("- ..", {8'h54, 120'h0}, 1, 1'b0);
        vecs[10] = mk({". . . . . ", ". . . . . ", ". . . . . ", ". . "}, {16{8'h45}}, 16, 1'b1);
        vecs[11] = mk({". . . . . ", ". . . . . ", ". . . . . ", "./. "}, {16{8'h45}}, 16, 1'b1);

        {Clear, Enter, EndSeq, Space, Dash, Dot} = 6'b0;
        Reset = 1'b0;
        #12;
        checkOutput("resetOut", translatedCharacters, 128'h0);
        checkOutput("resetCount", 128'(CharCount), 128'h0);
        checkOutput("resetFull", 128'(Full), 128'h0);
        checkOutput("resetValid", 128'(Valid), 128'h0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        for (int v = 0; v < 12; v++) begin
            runSeq(vecs[v].seq, '{out: vecs[v].expOut, cnt: vecs[v].expCnt, full: vecs[v].expFull});
        end
        drain();

        // Buffer is full from the last vector; Clear then a separate Enter.
        applyStimulus(B_CLEAR);
        sendEnter('{out: 128'h0, cnt: 5'd0, full: 1'b0}, 1'b0);

        // Clear and Enter in the same cycle publish the emptied buffer.
        applyStimulus(B_DOT);
        applyStimulus(B_SPACE);
        sendEnter('{out: 128'h0, cnt: 5'd0, full: 1'b0}, 1'b1);

        // Held Dot acts once.
        applyStimulus(B_CLEAR);
        Dot = 1'b1;
        repeat (5) @(negedge Clk);
        Dot = 1'b0;
        @(negedge Clk);
        applyStimulus(B_SPACE);
        sendEnter('{out: {8'h45, 120'h0}, cnt: 5'd1, full: 1'b0}, 1'b0);
        drain();

        // Asynchronous reset mid-letter wipes the published output and the accumulator.
        applyStimulus(B_DOT);
        applyStimulus(B_DASH);
        #3 Reset = 1'b0;
        #1;
        checkOutput("asyncResetOut", translatedCharacters, 128'h0);
        checkOutput("asyncResetCount", 128'(CharCount), 128'h0);
        checkOutput("asyncResetValid", 128'(Valid), 128'h0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        applyStimulus(B_DOT);
        applyStimulus(B_SPACE);
        sendEnter('{out: {8'h45, 120'h0}, cnt: 5'd1, full: 1'b0}, 1'b0);
        drain();

        repeat (3) @(negedge Clk);
        checkOutput("validCount", 128'(nValid), 128'(nEnter));

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
